// File: rtl/alu_operand_stage.sv
// Issue stage in front of the 32-bit ALU: decodes the instruction, reads
// operands from a local register file (with write-back bypass), stalls on
// read-after-write hazards via a busy-bit scoreboard and hands a registered
// {A, B, sel, rd} bundle to the ALU over a valid/ready handshake.
module alu_operand_stage #(
  parameter int NREG  = 16,
  parameter int IMM_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_sel,
  output logic [3:0]  out_rd,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [15:0] issued_cnt
);

  logic [31:0]     rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic        dec_imm;
  logic [2:0]  dec_sel;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [31:0] imm_ext;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] op_b;
  logic        wb_hit1;
  logic        wb_hit2;
  logic        haz1;
  logic        haz2;
  logic        blocked;
  logic        accept;

  assign dec_imm = in_instr[31];
  assign dec_sel = in_instr[30:28];
  assign dec_rd  = in_instr[27:24];
  assign dec_rs1 = in_instr[23:20];
  assign dec_rs2 = in_instr[19:16];
  assign imm_ext = {{(32-IMM_W){1'b0}}, in_instr[IMM_W-1:0]};

  assign wb_hit1 = wb_en && (wb_addr == dec_rs1) && (wb_addr != 4'd0);
  assign wb_hit2 = wb_en && (wb_addr == dec_rs2) && (wb_addr != 4'd0);

  // Operand read: R0 is hardwired zero, same-cycle write-back is forwarded
  always_comb begin
    rd_a = rf[dec_rs1];
    rd_b = rf[dec_rs2];
    if (dec_rs1 == 4'd0) rd_a = '0;
    else if (wb_hit1)    rd_a = wb_data;
    if (dec_rs2 == 4'd0) rd_b = '0;
    else if (wb_hit2)    rd_b = wb_data;
  end

  assign op_b = dec_imm ? imm_ext : rd_b;

  // pass-B ignores A, so its rs1 cannot create a hazard; an in-flight result
  // retiring this very cycle is forwarded, so it does not block either
  assign haz1    = (dec_sel != 3'b010) && busy[dec_rs1] && !wb_hit1;
  assign haz2    = !dec_imm && busy[dec_rs2] && !wb_hit2;
  assign blocked = haz1 || haz2;

  assign in_ready = rst_n && (!out_valid || out_ready) && !blocked;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: retire first, then a new claim wins on collision
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_addr] = 1'b0;
    if (accept && (dec_rd != 4'd0)) busy_nxt[dec_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Register file write port; R0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && (wb_addr != 4'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Output bundle: load on accept, otherwise hold; valid drops once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sel   <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= rd_a;
      out_b     <= op_b;
      out_sel   <= dec_sel;
      out_rd    <= dec_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accepted-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      issued_cnt <= '0;
    else if (accept) issued_cnt <= issued_cnt + 16'd1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed vectors plus
// sequences for hazards, back-pressure, bypass, set/clear collision,
// asynchronous reset and counter wrap.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_sel;
  logic [3:0]  out_rd;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] issued_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_sel    (out_sel),
    .out_rd     (out_rd),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [3:0]  rd;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic [3:0] rd);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".a"},     out_a, a);
    chk({name, ".b"},     out_b, b);
    chk({name, ".sel"},   {29'd0, out_sel}, {29'd0, sel});
    chk({name, ".rd"},    {28'd0, out_rd}, {28'd0, rd});
    chk({name, ".cnt"},   {16'd0, issued_cnt}, {16'd0, exp_cnt});
  endtask

  task automatic wb(input logic [3:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    // imm | sel | rd | rs1 | rs2 | imm16
    vecs[0] = '{32'h4C89_0000, 32'h8888_0008, 32'h9999_0009, 3'd4, 4'd12};
    vecs[1] = '{32'hDDB0_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 3'd5, 4'd13};
    vecs[2] = '{32'h205A_0000, 32'h0000_0000, 32'hAAAA_000A, 3'd2, 4'd0};
    vecs[3] = '{32'h7E03_0000, 32'h0000_0000, 32'h0000_0010, 3'd7, 4'd14};
    vecs[4] = '{32'hEF40_0000, 32'h0000_0055, 32'h0000_0000, 3'd6, 4'd15};
    vecs[5] = '{32'h1010_0000, 32'h0000_0005, 32'h0000_0000, 3'd1, 4'd0};

    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h8000_0000;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    exp_cnt = '0;
    #12;
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.cnt",       {16'd0, issued_cnt}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // basic add
    wb(4'd1, 32'd5);
    wb(4'd2, 32'd3);
    in_instr = 32'h0312_0000; in_valid = 1'b1;
    #1 chk("basic.in_ready", {31'd0, in_ready}, 32'd1);
    tick(); exp_cnt++;
    chk_out("basic", 32'd5, 32'd3, 3'd0, 4'd3);

    // RAW on R3
    in_instr = 32'h0030_0000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw.stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h10;
    #1 chk("raw.release", {31'd0, in_ready}, 32'd1);
    tick(); exp_cnt++;
    wb_en = 1'b0; in_valid = 1'b0;
    chk_out("raw", 32'h10, 32'd0, 3'd0, 4'd0);
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // back-pressure
    out_ready = 1'b0;
    in_instr = 32'h9510_1234; in_valid = 1'b1;
    tick(); exp_cnt++;
    chk_out("bp.load", 32'd5, 32'h1234, 3'd1, 4'd5);
    in_instr = 32'h3621_0000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk_out("bp.hold", 32'd5, 32'h1234, 3'd1, 4'd5);
    end
    out_ready = 1'b1;
    #1 chk("bp.resume", {31'd0, in_ready}, 32'd1);
    tick(); exp_cnt++;
    chk_out("bp.next", 32'd3, 32'd5, 3'd3, 4'd6);

    // pass-B with busy rs1, immediate extension
    in_instr = 32'hA750_BEEF;
    #1 chk("imm.in_ready", {31'd0, in_ready}, 32'd1);
    tick(); exp_cnt++;
    chk_out("imm", 32'd0, 32'h0000_BEEF, 3'd2, 4'd7);

    // R0 write ignored, even with bypass
    in_instr = 32'h8000_0001;
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hFF;
    tick(); exp_cnt++;
    wb_en = 1'b0;
    chk_out("r0.byp", 32'd0, 32'd1, 3'd0, 4'd0);
    tick(); exp_cnt++;
    chk_out("r0.rf", 32'd0, 32'd1, 3'd0, 4'd0);

    // simultaneous set and clear of R4
    in_instr = 32'h8400_0000;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    tick(); exp_cnt++;
    wb_en = 1'b0;
    chk_out("setclr", 32'd0, 32'd0, 3'd0, 4'd4);
    in_instr = 32'h8040_0000;
    for (int i = 0; i < 2; i++) begin
      #1 chk("setclr.stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h55;
    tick(); exp_cnt++;
    wb_en = 1'b0; in_valid = 1'b0;
    chk_out("setclr.byp", 32'h55, 32'd0, 3'd0, 4'd0);

    // write-backs to non-busy registers
    wb(4'd8,  32'h8888_0008);
    wb(4'd9,  32'h9999_0009);
    wb(4'd10, 32'hAAAA_000A);
    wb(4'd11, 32'hFFFF_FFFF);

    // table, back-to-back
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = vecs[i].instr;
      #1 chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      tick(); exp_cnt++;
      chk_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].rd);
    end

    // async reset mid-stall
    out_ready = 1'b0;
    in_instr = 32'h00C1_0000;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid",    {31'd0, out_valid}, 32'd0);
    chk("arst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst.a",        out_a, 32'd0);
    chk("arst.cnt",      {16'd0, issued_cnt}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_cnt = '0;
    #1 chk("arst.busy_clr", {31'd0, in_ready}, 32'd1);

    // counter wrap
    for (int i = 1; i <= 65536; i++) begin
      tick();
      if (i == 1) begin
        chk("wrap.a_rf_clr", out_a, 32'd0);
        chk("wrap.b_rf_clr", out_b, 32'd0);
      end
      if (i == 65535) chk("wrap.max", {16'd0, issued_cnt}, 32'h0000_FFFF);
    end
    chk("wrap.zero", {16'd0, issued_cnt}, 32'd0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 32-bit ALU (3-bit sel, outputs C/ZF/SF).
- Decodes a 32-bit instruction and reads operands from an internal 16x32 register file.
- Presents a registered {A, B, sel, rd} bundle to the ALU with a valid/ready handshake.
- Tracks in-flight destinations with a busy-bit scoreboard and stalls on read-after-write hazards until the write-back port retires the result.

Parameters:
- NREG, 16, number of architectural registers (R0 reads as zero and is never written).
- IMM_W, 16, immediate field width; zero-extended to 32 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction available
- in_ready  output  1  stage accepts instruction this cycle
- in_instr  input  32  instruction word
- out_valid  output  1  operand bundle valid toward ALU
- out_ready  input  1  downstream consumes bundle this cycle
- out_a  output  32  ALU operand A
- out_b  output  32  ALU operand B
- out_sel  output  3  ALU operation select
- out_rd  output  4  destination register carried to write-back
- wb_en  input  1  write-back strobe
- wb_addr  input  4  write-back register
- wb_data  input  32  write-back value
- issued_cnt  output  16  count of accepted instructions, wraps at 0xFFFF->0

Behaviour:
- Instruction fields:
  - [31] imm: 1 selects B = zero-extended [15:0].
  - [30:28] sel.
  - [27:24] rd.
  - [23:20] rs1.
  - [19:16] rs2.
- Operand A = RF[rs1].
- Operand B = RF[rs2] if imm=0, else the zero-extended immediate.
- Register reads of R0 return 0.
- Write-back bypass: if wb_en and wb_addr==rsX and wb_addr!=0 in the same cycle, the read returns wb_data.
- Register file:
  - Write on clk when wb_en and wb_addr!=0.
  - Writes to R0 are ignored.
- Scoreboard: busy[NREG-1:0].
  - rs1 is checked unless sel==3'b010 (pass-B).
  - rs2 is checked only when imm=0.
  - A checked source is blocked if busy[src]=1 and not (wb_en and wb_addr==src) in the same cycle.
  - busy[0] is always 0.
- in_ready = (!out_valid || out_ready) && !blocked. in_ready is a function of the current instruction; the upstream holds in_instr stable while in_valid && !in_ready.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_* load the decoded values.
  - out_valid=1.
  - busy[rd] set when rd!=0.
  - issued_cnt increments.
- Latency: exactly 1 cycle from accept to out_valid.
- Full throughput: one instruction per cycle when there are no hazards and out_ready=1.
- No accept and out_valid && out_ready: out_valid clears at the next edge; out_a/out_b/out_sel/out_rd hold their last values.
- out_valid && !out_ready: all out_* hold stable, no accept occurs, and the stall may last indefinitely.
- wb_en clears busy[wb_addr] at the next edge.
- Simultaneous accept with rd==R and wb_en with wb_addr==R: busy[R] ends at 1 (set wins).
- A write-back to a non-busy register is legal: it writes the register file and busy stays 0.
- Reset (asynchronous, may occur mid-stall or mid-transfer) clears:
  - out_valid=0.
  - out_a, out_b, out_sel, out_rd = 0.
  - all busy bits = 0.
  - all registers = 0.
  - issued_cnt=0.
- in_ready is 0 while rst_n=0 and combinational thereafter.

Test Plan:
- Reset, then wb R1=5 and R2=3; send imm=0, sel=000, rd=3, rs1=1, rs2=2 with out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=3, out_sel=000, out_rd=3, busy[3]=1, issued_cnt=1.
- RAW hazard: send an instruction with rd=3, then one reading rs1=3 -> in_ready=0 until wb_en addr=3 data=0x10. In that same wb cycle the second instruction is accepted, and the next cycle out_a=0x10.
- Back-pressure: out_ready=0 with out_valid=1 for 4 cycles -> out_* stable, in_ready=0, issued_cnt unchanged. Raise out_ready -> the next queued instruction issues in the following cycle.
- Immediate and R0: imm=1, sel=010, rs1=5 (busy), [15:0]=0xBEEF -> not stalled, out_b=0x0000BEEF. Read of rs1=0 after wb_en addr=0 data=0xFF -> out_a=0.
- Simultaneous set/clear: accept rd=4 in the same cycle as wb_en addr=4 -> busy[4]=1 afterwards, and a following reader of R4 stalls.
- Asynchronous reset asserted mid-stall with out_valid=1 -> out_valid=0 and busy=0 immediately; drive 0x10000 accepts -> issued_cnt wraps to 0.
